// File: rtl/uart_bus_master_pkg.sv
// Shared definitions for the UART-to-bus initiator.
//   - state_t: top-level FSM states
//   - command / response byte values of the host protocol
//   - addresses of the peripheral registers the host normally pokes
package uart_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_READ,
    ST_RESP
  } state_t;

  localparam logic [7:0] CMD_WR   = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD   = 8'h52;  // 'R'
  localparam logic [7:0] ACK_BYTE = 8'h4B;  // 'K'
  localparam logic [7:0] ERR_BYTE = 8'h3F;  // '?'

  localparam logic [31:0] REG_TIMER_CTRL  = 32'h4000_0000;
  localparam logic [31:0] REG_TIMER_LOAD  = 32'h4000_0004;
  localparam logic [31:0] REG_TIMER_VALUE = 32'h4000_0008;
  localparam logic [31:0] REG_LED         = 32'h4000_000C;
  localparam logic [31:0] REG_DIGIT_LO    = 32'h4000_0010;
  localparam logic [31:0] REG_DIGIT_HI    = 32'h4000_0014;
  localparam logic [31:0] REG_UART_DATA   = 32'h4000_0018;
  localparam logic [31:0] REG_UART_STATUS = 32'h4000_001C;
  localparam logic [31:0] REG_UART_BAUD   = 32'h4000_0020;

endpackage

// File: rtl/uart_bus_resp_shifter.sv
// Response serializer: loads a 1- or 4-byte response and presents it MSB
// first on a valid/ready byte interface.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load              one-cycle request to capture a new response
//   word              1: four bytes from load_data; 0: one byte load_data[31:24]
//   load_data         response contents, first byte in bits [31:24]
//   tx_data/tx_valid  current byte, held until tx_ready
//   tx_ready          consumer accepts the byte
//   done              combinational: the last byte is being accepted this cycle
module uart_bus_resp_shifter
  import uart_bus_master_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        word,
  input  logic [31:0] load_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        done
);

  logic [31:0] sreg;
  logic [2:0]  left;

  // Shifting zeros in behind the data means tx_data returns to 0 once the
  // response has drained, so no stale byte lingers on the port.
  assign tx_data = sreg[31:24];
  assign done    = tx_valid && tx_ready && (left == 3'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg     <= 32'h0;
      left     <= 3'd0;
      tx_valid <= 1'b0;
    end else if (load) begin
      sreg     <= word ? load_data : {load_data[31:24], 24'h0};
      left     <= word ? 3'd4 : 3'd1;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      sreg <= {sreg[23:0], 8'h0};
      left <= left - 3'd1;
      if (left == 3'd1) begin
        tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_bus_master.sv
// UART byte stream to peripheral-bus initiator.
// A host sends 'W' addr[4] data[4] or 'R' addr[4] (big-endian); the block
// performs one bus write or read and answers with 'K', the 4 read bytes,
// or '?' for an unknown command byte.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   rx_data/rx_valid   received byte with one-cycle strobe
//   tx_data/tx_valid   response byte, held until tx_ready
//   tx_ready           transmitter accepts the byte
//   rd, wr             one-cycle bus strobes
//   addr, wdata        bus address / write data (hold between transactions)
//   rdata              bus read data, combinational from addr while rd=1
//   busy               FSM not in IDLE
//   frame_err          one-cycle pulse on timeout or unknown command
module uart_bus_master
  import uart_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        frame_err
);

  localparam int              TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic          cmd_wr;
  logic [1:0]    bcnt;
  logic [TW-1:0] tcnt;

  logic          resp_load;
  logic          resp_word;
  logic [31:0]   resp_data;
  logic          resp_done;

  assign busy = (state != ST_IDLE);

  // Response loading is decoded from the current state so the shifter
  // captures at the same edge the FSM moves into RESP; READ samples rdata
  // while rd is still high.
  always_comb begin
    resp_load = 1'b0;
    resp_word = 1'b0;
    resp_data = 32'h0;
    case (state)
      ST_IDLE: begin
        if (rx_valid && (rx_data != CMD_WR) && (rx_data != CMD_RD)) begin
          resp_load = 1'b1;
          resp_data = {ERR_BYTE, 24'h0};
        end
      end
      ST_WRITE: begin
        resp_load = 1'b1;
        resp_data = {ACK_BYTE, 24'h0};
      end
      ST_READ: begin
        resp_load = 1'b1;
        resp_word = 1'b1;
        resp_data = rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cmd_wr    <= 1'b0;
      bcnt      <= 2'd0;
      tcnt      <= '0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      addr      <= 32'h0;
      wdata     <= 32'h0;
      frame_err <= 1'b0;
    end else begin
      rd        <= 1'b0;
      wr        <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
              cmd_wr <= (rx_data == CMD_WR);
              bcnt   <= 2'd0;
              tcnt   <= '0;
              state  <= ST_ADDR;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (rx_valid) begin
            tcnt <= '0;
            bcnt <= bcnt + 2'd1;  // wraps to 0 after the 4th byte
            if (state == ST_ADDR) begin
              addr <= {addr[23:0], rx_data};
              if (bcnt == 2'd3) begin
                if (cmd_wr) begin
                  state <= ST_DATA;
                end else begin
                  state <= ST_READ;
                  rd    <= 1'b1;
                end
              end
            end else begin
              wdata <= {wdata[23:0], rx_data};
              if (bcnt == 2'd3) begin
                state <= ST_WRITE;
                wr    <= 1'b1;
              end
            end
          end else if (tcnt == TLAST) begin
            // Abandon the frame silently; partially shifted addr/wdata stay.
            tcnt      <= '0;
            frame_err <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_WRITE: state <= ST_RESP;
        ST_READ:  state <= ST_RESP;
        ST_RESP: begin
          if (resp_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_bus_resp_shifter u_resp (
    .clk       (clk),
    .reset     (reset),
    .load      (resp_load),
    .word      (resp_word),
    .load_data (resp_data),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (resp_done)
  );

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        frame_err;

  uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Bus model: one readable register.
  assign rdata = (rd && addr == 32'h4000_0010) ? 32'h1234_5678 : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Transmitter model: ready always, or low 3 cycles then high 1 per byte.
  logic stall_mode;
  int   ph = 0;
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      tx_ready = 1'b1;
      ph = 0;
    end else if (tx_valid) begin
      tx_ready = (ph == 3);
      ph = (ph == 3) ? 0 : ph + 1;
    end else begin
      tx_ready = 1'b0;
      ph = 0;
    end
  end

  // Monitor: records what the DUT does, sampled on the falling edge.
  logic [7:0]  obs_tx [256];
  int          obs_n = 0;
  int          wr_cnt = 0, rd_cnt = 0, both_cnt = 0, fe_cnt = 0, stall_err = 0;
  int          wr_cyc = 0, rd_cyc = 0, fe_cyc = 0, rise_cyc = 0, acc_cyc = 0;
  logic [31:0] wr_addr = 0, wr_wdata = 0;
  logic        prev_txv = 0, prev_stalled = 0;
  logic [7:0]  prev_data = 0;

  always @(negedge clk) begin
    if (wr) begin wr_cnt++; wr_cyc = cyc; wr_addr = addr; wr_wdata = wdata; end
    if (rd) begin rd_cnt++; rd_cyc = cyc; end
    if (rd && wr) both_cnt++;
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (tx_valid && !prev_txv) rise_cyc = cyc;
    if (prev_stalled && tx_valid && tx_data !== prev_data) stall_err++;
    if (tx_valid && tx_ready) begin
      obs_tx[obs_n % 256] = tx_data;
      obs_n++;
      acc_cyc = cyc;
    end
    prev_stalled = tx_valid && !tx_ready;
    prev_data    = tx_data;
    prev_txv     = tx_valid;
  end

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         rd_ptr = 0;
  int         last_cyc = 0;
  int         s_wr, s_rd, s_fe, s_st, s_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    last_cyc = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic snap();
    s_wr = wr_cnt; s_rd = rd_cnt; s_fe = fe_cnt; s_st = stall_err; s_obs = obs_n;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || tx_valid) && n < 200) begin tick(1); n++; end
    check(tag, 32'(busy || tx_valid), 32'd0);
  endtask

  task automatic wait_txv(input string tag);
    int n = 0;
    while (!tx_valid && n < 50) begin tick(1); n++; end
    check(tag, 32'(tx_valid), 32'd1);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      logic [7:0] e = exp_q.pop_front();
      if (rd_ptr < obs_n) begin
        check(tag, 32'(obs_tx[rd_ptr % 256]), 32'(e));
        rd_ptr++;
      end else begin
        check({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
      end
    end
    check({tag, "_extra"}, 32'(obs_n - rd_ptr), 32'd0);
    rd_ptr = obs_n;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"}, 32'(rd), 32'd0);
    check({tag, "_wr"}, 32'(wr), 32'd0);
    check({tag, "_addr"}, addr, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
  endtask

  task automatic write_frame_checked(input string tag);
    snap();
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_word(32'h4000_000C);
    send_word(32'h0000_00A5);
    wait_idle({tag, "_idle"});
    check({tag, "_wr_cnt"}, 32'(wr_cnt - s_wr), 32'd1);
    check({tag, "_wr_addr"}, wr_addr, 32'h4000_000C);
    check({tag, "_wr_wdata"}, wr_wdata, 32'h0000_00A5);
    check({tag, "_wr_lat"}, 32'(wr_cyc - last_cyc), 32'd1);
    check({tag, "_txv_lat"}, 32'(rise_cyc - last_cyc), 32'd2);
    check({tag, "_rd_cnt"}, 32'(rd_cnt - s_rd), 32'd0);
    drain({tag, "_tx"});
  endtask

  task automatic read_frame_checked(input string tag, input int gap);
    snap();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    send_byte(8'h52);
    if (gap > 0) tick(gap);
    send_word(32'h4000_0010);
    wait_idle({tag, "_idle"});
    check({tag, "_rd_cnt"}, 32'(rd_cnt - s_rd), 32'd1);
    check({tag, "_rd_lat"}, 32'(rd_cyc - last_cyc), 32'd1);
    check({tag, "_txv_lat"}, 32'(rise_cyc - last_cyc), 32'd2);
    check({tag, "_last_acc"}, 32'(acc_cyc - last_cyc), 32'd5);
    check({tag, "_wr_cnt"}, 32'(wr_cnt - s_wr), 32'd0);
    check({tag, "_fe_cnt"}, 32'(fe_cnt - s_fe), 32'd0);
    drain({tag, "_tx"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; stall_mode = 1'b0;
    tick(3);
    check_reset_outputs("rst0");
    reset = 1'b0;
    tick(2);

    // Write frame
    write_frame_checked("wr1");

    // Read frame
    read_frame_checked("rd1", 0);

    // Read with tx backpressure; rx bytes during the response are ignored
    stall_mode = 1'b1;
    tick(1);
    snap();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    exp_q.push_back(8'h56); exp_q.push_back(8'h78);
    send_byte(8'h52);
    send_word(32'h4000_0010);
    wait_txv("st_txv");
    send_byte(8'h57);
    tick(2);
    send_byte(8'h41);
    wait_idle("st_idle");
    check("st_stable", 32'(stall_err - s_st), 32'd0);
    check("st_span", 32'(acc_cyc - rise_cyc), 32'd15);
    check("st_fe_cnt", 32'(fe_cnt - s_fe), 32'd0);
    check("st_wr_cnt", 32'(wr_cnt - s_wr), 32'd0);
    check("st_rd_cnt", 32'(rd_cnt - s_rd), 32'd1);
    drain("st_tx");
    stall_mode = 1'b0;
    tick(2);

    // Unknown command byte
    snap();
    exp_q.push_back(8'h3F);
    send_byte(8'h41);
    check("unk_fe", 32'(frame_err), 32'd1);
    wait_idle("unk_idle");
    check("unk_fe_cnt", 32'(fe_cnt - s_fe), 32'd1);
    check("unk_rdwr", 32'((rd_cnt - s_rd) + (wr_cnt - s_wr)), 32'd0);
    drain("unk_tx");

    // Timeout after 57 40 00
    snap();
    send_byte(8'h57);
    send_byte(8'h40);
    send_byte(8'h00);
    tick(20);
    check("to_fe_cnt", 32'(fe_cnt - s_fe), 32'd1);
    check("to_fe_lat", 32'(fe_cyc - last_cyc), 32'd17);
    check("to_busy", 32'(busy), 32'd0);
    check("to_no_tx", 32'(obs_n - s_obs), 32'd0);
    check("to_wr_cnt", 32'(wr_cnt - s_wr), 32'd0);
    check("to_addr", addr, 32'h0010_4000);
    read_frame_checked("rd2", 0);

    // A 15-cycle gap inside a frame stays just under the timeout
    read_frame_checked("rd_gap", 15);

    // Reset in DATA after 2 data bytes
    send_byte(8'h57);
    send_word(32'h4000_000C);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("rst_data");
    reset = 1'b0;
    tick(1);
    write_frame_checked("wr2");

    // Reset mid read response
    stall_mode = 1'b1;
    tick(1);
    send_byte(8'h52);
    send_word(32'h4000_0010);
    wait_txv("rr_txv");
    tick(5);
    reset = 1'b1;
    tick(1);
    check_reset_outputs("rst_resp");
    reset = 1'b0;
    stall_mode = 1'b0;
    tick(2);
    rd_ptr = obs_n;
    write_frame_checked("wr3");

    check("no_rd_wr_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
